alu_issue: RTL

Pipeline stage directly upstream of the ALU. Accepts one RV32I integer instruction per cycle with its register-file operands. Decodes it into the ALU operand pair and 4-bit function code, and presents the result as a registered, backpressurable output that drives the ALU's `x`/`y`/`fn` inputs. A two-entry skid buffer keeps full throughput under downstream stalls.

---
 rtl/alu_pkg.sv | 46 ++++
 rtl/alu_decode.sv | 93 +++++++++
 rtl/alu_issue.sv | 96 +++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the integer ALU and its issue stage: function codes,
// RV32I opcode values and the decoded entry carried through the issue buffer.
package alu_pkg;

  localparam int unsigned XLEN = 32;

  // ALU function code is {sub_sra, funct3}
  localparam logic [3:0] FN_ADD  = 4'h0;
  localparam logic [3:0] FN_SLL  = 4'h1;
  localparam logic [3:0] FN_SLT  = 4'h2;
  localparam logic [3:0] FN_SLTU = 4'h3;
  localparam logic [3:0] FN_XOR  = 4'h4;
  localparam logic [3:0] FN_SRL  = 4'h5;
  localparam logic [3:0] FN_OR   = 4'h6;
  localparam logic [3:0] FN_AND  = 4'h7;
  localparam logic [3:0] FN_SUB  = 4'h8;
  localparam logic [3:0] FN_SRA  = 4'hD;

  // Major opcodes handled by the issue stage
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

  // One decoded instruction as presented to the ALU
  typedef struct packed {
    logic [XLEN-1:0] x;
    logic [XLEN-1:0] y;
    logic [3:0]      fn;
    logic [4:0]      rd;
    logic            wen;
    logic            illegal;
  } issue_entry_t;

  // The alternate funct7 only selects SUB (funct3 0) or SRA (funct3 5);
  // anything else outside the base encoding is not an RV32I ALU op.
  function automatic logic funct7_legal(input logic [6:0] funct7,
                                        input logic [2:0] funct3);
    return (funct7 == FUNCT7_BASE) ||
           ((funct7 == FUNCT7_ALT) && ((funct3 == 3'd0) || (funct3 == 3'd5)));
  endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational RV32I decoder: turns an instruction plus its operands into the
// ALU operand pair, function code and writeback information.
module alu_decode
  import alu_pkg::*;
(
  input  logic [31:0]  insn,
  input  logic [31:0]  pc,
  input  logic [31:0]  rs1_val,
  input  logic [31:0]  rs2_val,
  output issue_entry_t entry
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd;
  logic [4:0] shamt;
  logic [31:0] imm_i;
  logic [31:0] imm_u;
  logic        legal;
  logic [31:0] x;
  logic [31:0] y;
  logic [3:0]  fn;

  // Register source fields are consumed upstream by the register file read
  logic unused_rs_fields;
  assign unused_rs_fields = ^insn[19:15];

  assign opcode = insn[6:0];
  assign rd     = insn[11:7];
  assign funct3 = insn[14:12];
  assign funct7 = insn[31:25];
  assign shamt  = insn[24:20];
  assign imm_i  = {{20{insn[31]}}, insn[31:20]};
  assign imm_u  = {insn[31:12], 12'b0};

  // Select operands and function code by opcode
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    legal = 1'b0;
    x     = '0;
    y     = '0;
    fn    = FN_ADD;
    unique case (opcode)
      OPC_OP: begin
        legal = funct7_legal(funct7, funct3);
        x     = rs1_val;
        y     = rs2_val;
        fn    = {funct7[5], funct3};
      end
      OPC_OP_IMM: begin
        x = rs1_val;
        if ((funct3 == 3'd1) || (funct3 == 3'd5)) begin
          legal = funct7_legal(funct7, funct3);
          y     = {27'b0, shamt};
          fn    = {insn[30], funct3};
        end else begin
          // insn[30] is immediate data here, so it never turns ADDI into SUB
          legal = 1'b1;
          y     = imm_i;
          fn    = {1'b0, funct3};
        end
      end
      OPC_LUI: begin
        legal = 1'b1;
        x     = '0;
        y     = imm_u;
        fn    = FN_ADD;
      end
      OPC_AUIPC: begin
        legal = 1'b1;
        x     = pc;
        y     = imm_u;
        fn    = FN_ADD;
      end
      default: legal = 1'b0;
    endcase
  end

  // Illegal entries still flow in order but carry no operands and no writeback
  always_comb begin
    entry         = '0;
    entry.rd      = rd;
    entry.illegal = !legal;
    entry.wen     = legal && (rd != 5'd0);
    if (legal) begin
      entry.x  = x;
      entry.y  = y;
      entry.fn = fn;
    end
  end

endmodule

// File: rtl/alu_issue.sv
// Issue stage in front of the ALU: decodes each accepted instruction and holds
// it in a two-entry skid buffer so in_ready never depends on out_ready.
module alu_issue
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_insn,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_rs1_val,
  input  logic [31:0] in_rs2_val,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_x,
  output logic [31:0] out_y,
  output logic [3:0]  out_fn,
  output logic [4:0]  out_rd,
  output logic        out_wen,
  output logic        out_illegal
);

  issue_entry_t dec_entry;
  issue_entry_t main_q;
  issue_entry_t skid_q;
  logic         main_valid;
  logic         skid_valid;
  logic         in_xfer;
  logic         out_xfer;
  logic         main_free;

  alu_decode u_decode (
    .insn    (in_insn),
    .pc      (in_pc),
    .rs1_val (in_rs1_val),
    .rs2_val (in_rs2_val),
    .entry   (dec_entry)
  );

  // in_ready comes straight from the skid valid flop, never from out_ready
  assign in_ready  = !skid_valid;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = main_valid && out_ready;
  assign main_free = out_xfer || !main_valid;

  // Valid bits: flush empties both; main refills from skid first, then input
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (main_free) begin
      main_valid <= skid_valid || in_xfer;
      skid_valid <= 1'b0;
    end else if (in_xfer) begin
      skid_valid <= 1'b1;
    end
  end

  // Main payload: loads whenever main is free and something is available
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: payload registers are reset because the outputs must read zero out of reset; otherwise they would need no reset.
    if (!rst_n) begin
      main_q <= '0;
    end else if (!flush && main_free) begin
      if (skid_valid) begin
        main_q <= skid_q;
      end else if (in_xfer) begin
        main_q <= dec_entry;
      end
    end
  end

  // Skid payload: catches an accepted entry while main is held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_q <= '0;
    end else if (!flush && !main_free && in_xfer) begin
      skid_q <= dec_entry;
    end
  end

  assign out_valid   = main_valid;
  assign out_x       = main_q.x;
  assign out_y       = main_q.y;
  assign out_fn      = main_q.fn;
  assign out_rd      = main_q.rd;
  assign out_wen     = main_q.wen;
  assign out_illegal = main_q.illegal;

endmodule
